// File: rtl/icache_pkg.sv
// icache_pkg: cache geometry, FSM states, tag-entry layout and LRU age helper
package icache_pkg;
  localparam int WAYS = 4;
  localparam int SETS = 64;
  localparam int LINE_WORDS = 4;
  localparam int ADDR_W = 20;
  localparam int OFS_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int AGE_W = $clog2(WAYS);
  localparam int TAG_W = ADDR_W - 2 - OFS_W - IDX_W;
  localparam int ENTRY_W = 1 + AGE_W + TAG_W;
  typedef enum logic [1:0] {INIT, IDLE, LOOKUP, REFILL} state_t;
  typedef struct packed {
    logic             valid;
    logic [AGE_W-1:0] age;
    logic [TAG_W-1:0] tag;
  } tag_entry_t;
  // Touched way becomes youngest; only ways younger than it age by one, so ages stay a permutation
  function automatic logic [AGE_W-1:0] aged(input logic [AGE_W-1:0] age, input logic [AGE_W-1:0] old, input logic touched);
    return touched ? '0 : age < old ? age + 1'b1 : age;
  endfunction
endpackage

// File: rtl/icache_way.sv
// icache_way: one way's data and tag RAMs with registered reads
module icache_way
  import icache_pkg::*;
(
  input  logic                   CLK,
  input  logic                   rd_en,
  input  logic [IDX_W-1:0]       rd_idx,
  input  logic [OFS_W-1:0]       rd_ofs,
  input  logic                   tag_we,
  input  logic [IDX_W-1:0]       tag_widx,
  input  logic [ENTRY_W-1:0]     tag_wdata,
  input  logic                   data_we,
  input  logic [IDX_W+OFS_W-1:0] data_waddr,
  input  logic [31:0]            data_wdata,
  output logic [ENTRY_W-1:0]     tag_rdata,
  output logic [31:0]            data_rdata
);
  logic [31:0] data_mem [SETS*LINE_WORDS];
  logic [ENTRY_W-1:0] tag_mem [SETS];
  // Tag reads forward a same-cycle write so back-to-back hits to one set see fresh ages
  always_ff @(posedge CLK) begin
    if (data_we) data_mem[data_waddr] <= data_wdata;
    if (tag_we) tag_mem[tag_widx] <= tag_wdata;
    if (rd_en) data_rdata <= data_mem[{rd_idx, rd_ofs}];
    if (rd_en) tag_rdata <= (tag_we && tag_widx == rd_idx) ? tag_wdata : tag_mem[rd_idx];
  end
endmodule

// File: rtl/icache_nway.sv
// icache_nway: N-way set-associative instruction cache with burst refill, age LRU, invalidate sweep and flush
module icache_nway
  import icache_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              read_en,
  input  logic [ADDR_W-1:0] read_addr,
  input  logic              flush,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [31:0]       RDATA_OUT,
  output logic              cache_miss,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              fetch,
  input  logic [31:0]       write_data
);
  localparam int WA_W = ADDR_W - 2;
  state_t state, state_nx;
  logic [WA_W-1:0] req_wa;
  logic [IDX_W-1:0] sweep, req_idx, tag_widx;
  logic [OFS_W-1:0] beat, req_ofs;
  logic [TAG_W-1:0] req_tag;
  logic [AGE_W-1:0] hit_way, victim, upd_way;
  logic [31:0] cap_word;
  logic done, flush_pend, accept, hit, lookup_hit, beat_we, last_beat, tag_we, unused_lo;
  tag_entry_t tag_rd [WAYS];
  tag_entry_t tag_wr [WAYS];
  logic [31:0] data_rd [WAYS];
  assign req_ofs = req_wa[OFS_W-1:0];
  assign req_idx = req_wa[OFS_W +: IDX_W];
  assign req_tag = req_wa[WA_W-1 -: TAG_W];
  assign unused_lo = ^read_addr[1:0];
  // Victim: oldest way, overridden by the lowest-index invalid way
  always_comb begin
    hit = 1'b0;
    hit_way = '0;
    victim = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (tag_rd[w].valid && tag_rd[w].tag == req_tag) begin
        hit = 1'b1;
        hit_way = AGE_W'(w);
      end
      if (tag_rd[w].age == AGE_W'(WAYS - 1)) victim = AGE_W'(w);
    end
    for (int w = WAYS - 1; w >= 0; w--)
      if (!tag_rd[w].valid) victim = AGE_W'(w);
  end
  assign lookup_hit = state == LOOKUP && hit;
  assign beat_we = state == REFILL && !done && fetch;
  assign last_beat = beat_we && beat == OFS_W'(LINE_WORDS - 1);
  assign upd_way = state == REFILL ? victim : hit_way;
  assign tag_we = state == INIT || lookup_hit || last_beat;
  assign tag_widx = state == INIT ? sweep : req_idx;
  always_comb begin
    for (int w = 0; w < WAYS; w++)
      tag_wr[w] = state == INIT ? tag_entry_t'{valid: 1'b0, age: AGE_W'(w), tag: '0}
                : (state == REFILL && AGE_W'(w) == victim) ? tag_entry_t'{valid: 1'b1, age: '0, tag: req_tag}
                : tag_entry_t'{valid: tag_rd[w].valid,
                               age: aged(tag_rd[w].age, tag_rd[upd_way].age, AGE_W'(w) == upd_way),
                               tag: tag_rd[w].tag};
  end
  for (genvar i = 0; i < WAYS; i++) begin : g_way
    icache_way u_way (
      .CLK        (CLK),
      .rd_en      (accept),
      .rd_idx     (read_addr[OFS_W+2 +: IDX_W]),
      .rd_ofs     (read_addr[2 +: OFS_W]),
      .tag_we     (tag_we),
      .tag_widx   (tag_widx),
      .tag_wdata  (tag_wr[i]),
      .data_we    (beat_we && victim == AGE_W'(i)),
      .data_waddr ({req_idx, beat}),
      .data_wdata (write_data),
      .tag_rdata  (tag_rd[i]),
      .data_rdata (data_rd[i])
    );
  end
  always_ff @(posedge CLK) state <= RST ? INIT : state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      INIT:    state_nx = !flush && sweep == IDX_W'(SETS - 1) ? IDLE : INIT;
      IDLE:    state_nx = flush ? INIT : accept ? LOOKUP : IDLE;
      LOOKUP:  state_nx = !hit ? REFILL : (flush || flush_pend) ? INIT : accept ? LOOKUP : IDLE;
      REFILL:  state_nx = !done ? REFILL : (flush || flush_pend) ? INIT : IDLE;
      default: state_nx = INIT;
    endcase
  end
  always_comb begin
    req_ready = !flush && (state == IDLE || (lookup_hit && !flush_pend));
    resp_valid = lookup_hit || (state == REFILL && done);
    RDATA_OUT = lookup_hit ? data_rd[hit_way] : resp_valid ? cap_word : '0;
    cache_miss = state == LOOKUP && !hit;
    mem_req = state == REFILL && !done;
    mem_addr = {req_wa[WA_W-1:OFS_W], (OFS_W + 2)'(0)};
  end
  assign accept = read_en && req_ready;
  always_ff @(posedge CLK) begin
    if (RST) begin
      sweep <= '0;
      beat <= '0;
      done <= 1'b0;
      flush_pend <= 1'b0;
      req_wa <= '0;
      cap_word <= '0;
    end else begin
      sweep <= state != INIT || flush ? '0 : sweep + 1'b1;
      beat <= state != REFILL ? '0 : beat + OFS_W'(beat_we);
      done <= last_beat;
      flush_pend <= state != INIT && (flush_pend || (flush && state != IDLE));
      if (accept) req_wa <= read_addr[ADDR_W-1:2];
      if (beat_we && beat == req_ofs) cap_word <= write_data;
    end
  end
endmodule
